pwm_bar_multi: RTL and testbench

Multi-channel successor to the single-channel level-to-PWM path. It drives CH independent PWM outputs from CH packed level inputs through a shared prescaler and a shared period counter. Duty updates are glitch-free: they apply only at period boundaries, with optional slew limiting for soft-start. An LED bar graph shows the duty of one selected channel. It sits between the level/ADC source and the pins, and replaces the separate reducer, LED decoder, divider and PWM blocks.

---
 rtl/pwm_bar_multi.sv | 93 +++++++++
 tb/tb_pwm_bar_multi.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bar_multi.sv
// Multi-channel PWM driver with a shared prescaler and period counter, duty
// updates latched only at period boundaries (optionally slew-limited), and an LED bar.
module pwm_bar_multi #(
    parameter int CH    = 2,
    parameter int IN_W  = 8,
    parameter int RES   = 4,
    parameter int DIV   = 1000,
    parameter int LEDS  = 8,
    parameter int SLEW  = 1,
    parameter int SEL_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 reloj,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CH*IN_W-1:0]   nivel,
    input  logic [SEL_W-1:0]     sel,
    output logic [CH-1:0]        pwm,
    output logic [LEDS-1:0]      led,
    output logic                 periodo_fin
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LW = RES + $clog2(LEDS + 1) + 1;

    logic [PW-1:0]          pre;
    logic [RES-1:0]         cnt;
    logic [RES-1:0]         cnt_next;
    logic [CH-1:0][RES-1:0] duty;
    logic [CH-1:0][RES-1:0] duty_next;
    logic                   tick;
    logic                   boundary;
    logic [RES-1:0]         duty_sel;
    logic [LW-1:0]          lit;
    logic [LEDS-1:0]        led_next;
    int                     t_v;
    int                     d_v;

    // Only the top RES bits of each level matter; the rest is dropped on purpose.
    logic nivel_unused;
    assign nivel_unused = ^nivel;

    assign tick     = enable && (pre == PW'(DIV - 1));
    assign boundary = tick && (&cnt);
    assign cnt_next = !enable ? '0 : (tick ? cnt + 1'b1 : cnt);

    // Within SLEW of the target the duty lands on it exactly, so it can never overshoot.
    always_comb begin
        duty_next = duty;
        t_v = 0;
        d_v = 0;
        for (int k = 0; k < CH; k++) begin
            t_v = int'(nivel[k*IN_W + IN_W - RES +: RES]);
            d_v = int'(duty[k]);
            if (boundary) begin
                if (SLEW == 0 || ((t_v - d_v) <= SLEW && (d_v - t_v) <= SLEW))
                    duty_next[k] = RES'(t_v);
                else if (t_v > d_v)
                    duty_next[k] = RES'(d_v + SLEW);
                else
                    duty_next[k] = RES'(d_v - SLEW);
            end
        end
    end

    // Ceiling scale of the selected duty onto the bar; out-of-range sel shows nothing.
    always_comb begin
        duty_sel = '0;
        for (int k = 0; k < CH; k++)
            if (int'(sel) == k)
                duty_sel = duty[k];
        lit = (LW'(duty_sel) * LW'(LEDS) + LW'((1 << RES) - 1)) >> RES;
        for (int i = 0; i < LEDS; i++)
            led_next[i] = (LW'(i) < lit);
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            pre         <= '0;
            cnt         <= '0;
            duty        <= '0;
            pwm         <= '0;
            led         <= '0;
            periodo_fin <= 1'b0;
        end else begin
            pre         <= (!enable || tick) ? '0 : pre + 1'b1;
            cnt         <= cnt_next;
            duty        <= duty_next;
            periodo_fin <= boundary;
            led         <= led_next;
            for (int k = 0; k < CH; k++)
                pwm[k] <= enable && (cnt_next < duty_next[k]);
        end
    end
endmodule

// File: tb/tb_pwm_bar_multi.sv
// Directed bench for pwm_bar_multi: one slew-limited DIV=4 instance and one
// direct-jump DIV=1 three-channel instance, checked against hand-computed values.
module tb_pwm_bar_multi;
    logic        reloj = 1'b0;
    logic        reset_a, enable_a, reset_b, enable_b;
    logic [15:0] nivel_a;
    logic [23:0] nivel_b;
    logic [0:0]  sel_a;
    logic [1:0]  sel_b;
    logic [1:0]  pwm_a;
    logic [2:0]  pwm_b;
    logic [7:0]  led_a, led_b;
    logic        fin_a, fin_b;
    int          checks = 0;
    int          errors = 0;

    always #5 reloj = ~reloj;

    pwm_bar_multi #(.CH(2), .IN_W(8), .RES(4), .DIV(4), .LEDS(8), .SLEW(1)) u_dut_a (
        .reloj(reloj), .reset(reset_a), .enable(enable_a), .nivel(nivel_a),
        .sel(sel_a), .pwm(pwm_a), .led(led_a), .periodo_fin(fin_a));

    pwm_bar_multi #(.CH(3), .IN_W(8), .RES(4), .DIV(1), .LEDS(8), .SLEW(0)) u_dut_b (
        .reloj(reloj), .reset(reset_b), .enable(enable_b), .nivel(nivel_b),
        .sel(sel_b), .pwm(pwm_b), .led(led_b), .periodo_fin(fin_b));

    // Samples one full period starting at a periodo_fin sample; optionally changes nivel at sample chg_i.
    task automatic measure(input int which, input int len, input int chg_i, input logic [23:0] chg,
                           output int hi0, output int hi1, output int hi2, output int fins,
                           output logic [7:0] led_mid);
        logic [2:0] p;
        hi0 = 0; hi1 = 0; hi2 = 0; fins = 0; led_mid = '0;
        for (int i = 0; i < len; i++) begin
            p = (which != 0) ? pwm_b : {1'b0, pwm_a};
            hi0 += int'(p[0]);
            hi1 += int'(p[1]);
            hi2 += int'(p[2]);
            if (i > 0) fins += (which != 0) ? int'(fin_b) : int'(fin_a);
            if (i == 2) led_mid = (which != 0) ? led_b : led_a;
            if (i == chg_i) begin
                if (which != 0) nivel_b = chg;
                else nivel_a = chg[15:0];
            end
            @(negedge reloj);
        end
    endtask

    task automatic wait_fin(input int which, input int limit, output bit ok, output int waited, output int hi0);
        ok = 1'b0; waited = 0; hi0 = 0;
        while (!ok && waited < limit) begin
            @(negedge reloj);
            waited++;
            if (((which != 0) ? fin_b : fin_a) == 1'b1) ok = 1'b1;
            else hi0 += (which != 0) ? int'(pwm_b[0]) : int'(pwm_a[0]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge reloj);
        checks++; if (pwm_a !== 2'b00) begin errors++; $display("[TB] FAIL reset_pwm_a: got %b expected 00", pwm_a); end
        checks++; if (led_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_led_a: got %h expected 00", led_a); end
        checks++; if (fin_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_fin_a: got %b expected 0", fin_a); end
        checks++; if (pwm_b !== 3'b000) begin errors++; $display("[TB] FAIL reset_pwm_b: got %b expected 000", pwm_b); end
        checks++; if (led_b !== 8'h00) begin errors++; $display("[TB] FAIL reset_led_b: got %h expected 00", led_b); end
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (2) @(negedge reloj);
        checks++; if (pwm_a !== 2'b00 || fin_a !== 1'b0) begin errors++; $display("[TB] FAIL idle_a: got pwm=%b fin=%b expected 00/0", pwm_a, fin_a); end
    endtask

    task automatic test_ramp_up();
        bit ok; int w, h0, h1, h2, f; logic [7:0] lm;
        int         exp_hi [10] = '{4, 8, 12, 16, 20, 24, 28, 32, 32, 32};
        logic [7:0] exp_l  [10] = '{8'h01, 8'h01, 8'h03, 8'h03, 8'h07, 8'h07, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
        nivel_a = {8'h00, 8'h80};
        sel_a = 1'b0;
        enable_a = 1'b1;
        wait_fin(0, 200, ok, w, h0);
        checks++; if (!ok || w != 64) begin errors++; $display("[TB] FAIL ramp_first_fin: got ok=%0d after %0d clocks expected 64", ok, w); end
        checks++; if (h0 != 0) begin errors++; $display("[TB] FAIL ramp_first_period: got %0d high expected 0", h0); end
        for (int m = 0; m < 10; m++) begin
            measure(0, 64, -1, 24'h0, h0, h1, h2, f, lm);
            checks++; if (h0 != exp_hi[m]) begin errors++; $display("[TB] FAIL ramp_up_hi[%0d]: got %0d expected %0d", m, h0, exp_hi[m]); end
            checks++; if (h1 != 0) begin errors++; $display("[TB] FAIL ramp_up_ch1[%0d]: got %0d expected 0", m, h1); end
            checks++; if (lm !== exp_l[m]) begin errors++; $display("[TB] FAIL ramp_up_led[%0d]: got %h expected %h", m, lm, exp_l[m]); end
            checks++; if (f != 0 || fin_a !== 1'b1) begin errors++; $display("[TB] FAIL ramp_up_fin[%0d]: got extra=%0d end=%b expected 0/1", m, f, fin_a); end
        end
    endtask

    task automatic test_ramp_down();
        int h0, h1, h2, f; logic [7:0] lm;
        int         exp_hi [7] = '{32, 28, 24, 20, 16, 12, 12};
        logic [7:0] exp_l  [7] = '{8'h0F, 8'h0F, 8'h07, 8'h07, 8'h03, 8'h03, 8'h03};
        nivel_a = {8'h00, 8'h30};
        for (int m = 0; m < 7; m++) begin
            measure(0, 64, -1, 24'h0, h0, h1, h2, f, lm);
            checks++; if (h0 != exp_hi[m]) begin errors++; $display("[TB] FAIL ramp_down_hi[%0d]: got %0d expected %0d", m, h0, exp_hi[m]); end
            checks++; if (lm !== exp_l[m]) begin errors++; $display("[TB] FAIL ramp_down_led[%0d]: got %h expected %h", m, lm, exp_l[m]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int w, h0, h1, h2, f; logic [7:0] lm;
        int         exp_hi [4] = '{4, 8, 12, 12};
        logic [7:0] exp_l  [4] = '{8'h01, 8'h01, 8'h03, 8'h03};
        repeat (4) @(negedge reloj);
        checks++; if (pwm_a[0] !== 1'b1 || led_a !== 8'h03) begin errors++; $display("[TB] FAIL pre_reset: got pwm=%b led=%h expected 1/03", pwm_a[0], led_a); end
        reset_a = 1'b1;
        @(negedge reloj);
        checks++; if (pwm_a !== 2'b00 || led_a !== 8'h00 || fin_a !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset: got pwm=%b led=%h fin=%b expected 00/00/0", pwm_a, led_a, fin_a); end
        reset_a = 1'b0;
        wait_fin(0, 200, ok, w, h0);
        checks++; if (!ok || w != 64 || h0 != 0) begin errors++; $display("[TB] FAIL post_reset_period: got ok=%0d clocks=%0d high=%0d expected 1/64/0", ok, w, h0); end
        for (int m = 0; m < 4; m++) begin
            measure(0, 64, -1, 24'h0, h0, h1, h2, f, lm);
            checks++; if (h0 != exp_hi[m] || lm !== exp_l[m]) begin errors++; $display("[TB] FAIL restart_ramp[%0d]: got high=%0d led=%h expected %0d/%h", m, h0, lm, exp_hi[m], exp_l[m]); end
        end
    endtask

    task automatic test_enable();
        bit ok; int w, h0, h1, h2, f; logic [7:0] lm;
        repeat (8) @(negedge reloj);
        checks++; if (pwm_a[0] !== 1'b1) begin errors++; $display("[TB] FAIL pre_disable: got %b expected 1", pwm_a[0]); end
        enable_a = 1'b0;
        @(negedge reloj);
        checks++; if (pwm_a !== 2'b00 || led_a !== 8'h03) begin errors++; $display("[TB] FAIL disable: got pwm=%b led=%h expected 00/03", pwm_a, led_a); end
        nivel_a = {8'h00, 8'hF0};
        repeat (20) @(negedge reloj);
        checks++; if (pwm_a !== 2'b00 || fin_a !== 1'b0 || led_a !== 8'h03) begin errors++; $display("[TB] FAIL disabled_hold: got pwm=%b fin=%b led=%h expected 00/0/03", pwm_a, fin_a, led_a); end
        enable_a = 1'b1;
        wait_fin(0, 200, ok, w, h0);
        // cnt=0 lasts only 3 clocks here because the enable edge itself spends the first prescaler step.
        checks++; if (!ok || w != 64 || h0 != 11) begin errors++; $display("[TB] FAIL reenable: got ok=%0d clocks=%0d high=%0d expected 1/64/11", ok, w, h0); end
        measure(0, 64, -1, 24'h0, h0, h1, h2, f, lm);
        checks++; if (h0 != 16 || f != 0 || fin_a !== 1'b1) begin errors++; $display("[TB] FAIL reenable_step: got high=%0d extra=%0d end=%b expected 16/0/1", h0, f, fin_a); end
    endtask

    task automatic test_direct_glitch();
        bit ok; int w, h0, h1, h2, f; logic [7:0] lm;
        nivel_b = {8'hA0, 8'h00, 8'hF0};
        sel_b = 2'd0;
        enable_b = 1'b1;
        wait_fin(1, 50, ok, w, h0);
        checks++; if (!ok || w != 16 || h0 != 0) begin errors++; $display("[TB] FAIL div1_first: got ok=%0d clocks=%0d high=%0d expected 1/16/0", ok, w, h0); end
        measure(1, 16, 5, {8'h50, 8'h10, 8'h30}, h0, h1, h2, f, lm);
        checks++; if (h0 != 15 || h1 != 0 || h2 != 10) begin errors++; $display("[TB] FAIL glitch_hold: got %0d/%0d/%0d expected 15/0/10", h0, h1, h2); end
        checks++; if (lm !== 8'hFF || f != 0 || fin_b !== 1'b1) begin errors++; $display("[TB] FAIL full_bar: got led=%h extra=%0d end=%b expected FF/0/1", lm, f, fin_b); end
        measure(1, 16, -1, 24'h0, h0, h1, h2, f, lm);
        checks++; if (h0 != 3 || h1 != 1 || h2 != 5) begin errors++; $display("[TB] FAIL new_duty: got %0d/%0d/%0d expected 3/1/5", h0, h1, h2); end
        checks++; if (lm !== 8'h03 || fin_b !== 1'b1) begin errors++; $display("[TB] FAIL new_led: got led=%h end=%b expected 03/1", lm, fin_b); end
    endtask

    task automatic test_led_sel();
        repeat (2) @(negedge reloj);
        sel_b = 2'd1;
        #1;
        checks++; if (led_b !== 8'h03) begin errors++; $display("[TB] FAIL sel_latency: got %h expected 03", led_b); end
        @(negedge reloj);
        checks++; if (led_b !== 8'h01) begin errors++; $display("[TB] FAIL sel1: got %h expected 01", led_b); end
        sel_b = 2'd2;
        @(negedge reloj);
        checks++; if (led_b !== 8'h07) begin errors++; $display("[TB] FAIL sel2: got %h expected 07", led_b); end
        sel_b = 2'd3;
        @(negedge reloj);
        checks++; if (led_b !== 8'h00) begin errors++; $display("[TB] FAIL sel_out_of_range: got %h expected 00", led_b); end
        sel_b = 2'd0;
        @(negedge reloj);
        checks++; if (led_b !== 8'h03) begin errors++; $display("[TB] FAIL sel0: got %h expected 03", led_b); end
    endtask

    task automatic test_enable_div1();
        bit ok; int w, h0, h1, h2, f; logic [7:0] lm;
        wait_fin(1, 40, ok, w, h0);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL div1_sync: got no pulse in %0d clocks expected pulse", w); end
        @(negedge reloj);
        checks++; if (pwm_b !== 3'b101) begin errors++; $display("[TB] FAIL div1_cnt1: got %b expected 101", pwm_b); end
        enable_b = 1'b0;
        @(negedge reloj);
        checks++; if (pwm_b !== 3'b000 || led_b !== 8'h03) begin errors++; $display("[TB] FAIL div1_disable: got pwm=%b led=%h expected 000/03", pwm_b, led_b); end
        nivel_b = {8'hF0, 8'hF0, 8'hF0};
        repeat (5) @(negedge reloj);
        enable_b = 1'b1;
        wait_fin(1, 40, ok, w, h0);
        checks++; if (!ok || w != 16 || h0 != 2) begin errors++; $display("[TB] FAIL div1_reenable: got ok=%0d clocks=%0d high=%0d expected 1/16/2", ok, w, h0); end
        measure(1, 16, -1, 24'h0, h0, h1, h2, f, lm);
        checks++; if (h0 != 15 || h1 != 15 || h2 != 15 || lm !== 8'hFF) begin errors++; $display("[TB] FAIL div1_all_max: got %0d/%0d/%0d led=%h expected 15/15/15 FF", h0, h1, h2, lm); end
    endtask

    initial begin
        reset_a = 1'b1; enable_a = 1'b0; nivel_a = '0; sel_a = '0;
        reset_b = 1'b1; enable_b = 1'b0; nivel_b = '0; sel_b = '0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_reset_mid();
        test_enable();
        test_direct_glitch();
        test_led_sel();
        test_enable_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
